dcache_line_memory: RTL and testbench
=====================================

// Module: dcache_line_memory
// PURPOSE
//  Off-chip data memory model behind the data cache's 256-bit line port.
//  Serves one full-line read or write per request after a fixed LATENCY,
//  signalling completion with a one-cycle ack_o pulse. The cache's miss
//  FSM drives enable/write/addr/data and waits on ack for both write-back
//  and refill. Requests are latched at acceptance, so the cache may change
//  inputs while the memory is busy.
// PARAMETERS
//  LATENCY   10   cycles from acceptance edge to ack edge; legal range >=1
//  ADDR_W    9    line-index width; DEPTH = 2**ADDR_W lines of 256 bits
// PORTS
//  clk_i     in   1    clock, all state changes on rising edge
//  rst_i     in   1    asynchronous reset, active-low
//  addr_i    in   32   byte address; line index = addr_i[5+ADDR_W-1:5]
//  data_i    in   256  write line data
//  enable_i  in   1    request valid, level-sensitive
//  write_i   in   1    1 = write line, 0 = read line
//  ack_o     out  1    one-cycle completion pulse (registered)
//  data_o    out  256  read line data (registered)
//  busy_o    out  1    high when not in IDLE (combinational from state)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, counter=0, ack_o=0, data_o=0,
//   busy_o=0. Array contents not reset. In-flight write dropped, not committed.
//  States: IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: at edge E0 with enable_i=1: latch index, data_i, write_i;
//   counter<=1; go BUSY. enable_i=0: stay IDLE.
//  BUSY: counter increments each edge. At edge E0+LATENCY:
//   write -> array[index]<=latched data; data_o unchanged.
//   read  -> data_o<=array[index].
//   ack_o<=1; go DONE. LATENCY=1: that edge is the first edge in BUSY.
//  DONE: ack_o high for exactly this cycle; next edge (E0+LATENCY+1)
//   ack_o<=0, go IDLE. No acceptance in DONE, even if enable_i=1.
//   The cache updates its request on the edge it samples ack.
//  Earliest next acceptance: E0+LATENCY+2. Back-to-back write-back then
//   refill with enable_i held high: two full transactions, no gap errors.
//  enable_i held high after ack with unchanged inputs: a new, repeated
//   transaction is accepted (by design, harmless).
//  enable_i/addr_i/data_i/write_i changes during BUSY/DONE: ignored.
//  Address: addr_i[4:0] ignored; bits above 5+ADDR_W-1 ignored (index wraps).
//  data_o holds its last read value until the next read completes;
//   writes never disturb data_o.
//  Counter width: $clog2(LATENCY+1); never wraps within a transaction.
// TESTING
//  1 Reset, then write line 0xA5..A5 @0x0000_0040, read back @0x0000_0040
//    -> read ack 10 cycles after acceptance, data_o=0xA5..A5.
//  2 Latency: LATENCY=10, read accepted at edge N -> ack_o=1 only in the
//    cycle between edges N+10 and N+11, busy_o high throughout.
//  3 Write-back + refill: write @0x400 then read @0x800 with enable_i held;
//    write_i drops at ack -> read accepted at N+12, data_o=old @0x800 line,
//    @0x400 holds new data.
//  4 Wrap: ADDR_W=9, write @0x0000_0020 then read @0x0000_4020 -> same
//    line returned.
//  5 Reset mid-write: assert rst_i at cycle 5 of a write -> ack_o=0,
//    data_o=0, busy_o=0 immediately; later read of that line -> old data.
//  6 Input churn: change addr_i/data_i every cycle during BUSY -> original
//    latched request completes unaltered.

Source files
------------

// File: rtl/dcache_line_memory.sv
// Off-chip line memory behind the data cache: one 256-bit line read or
// write per request, completed after a fixed latency with a one-cycle ack.
module dcache_line_memory #(
  parameter int LATENCY = 10,
  parameter int ADDR_W  = 9
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o,
  output logic         busy_o
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [255:0]      wdat_q;
  logic              wr_q;
  logic              accept;
  logic              finish;

  logic [255:0] mem [2**ADDR_W];

  // Offset bits and address bits above the index never select anything.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5+ADDR_W], addr_i[4:0]};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == LAST) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wdat_q <= '0;
      wr_q   <= 1'b0;
      ack_o  <= 1'b0;
      data_o <= '0;
    end else begin
      ack_o <= finish;
      if (accept) begin
        idx_q  <= addr_i[5 +: ADDR_W];
        wdat_q <= data_i;
        wr_q   <= write_i;
        cnt_q  <= CW'(1);
      end else if (state_q == BUSY && !finish) begin
        cnt_q <= cnt_q + 1'b1;
      end else begin
        cnt_q <= '0;
      end
      if (finish && !wr_q) begin
        data_o <= mem[idx_q];
      end
    end
  end

  // Array is not reset; a reset during BUSY leaves finish low, so the
  // pending write is simply dropped.
  always_ff @(posedge clk_i) begin
    if (finish && wr_q) begin
      mem[idx_q] <= wdat_q;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_line_memory.sv
// Bench for dcache_line_memory: directed and random line transactions
// against an array model with per-cycle ack/busy/data_o expectations.
module tb_dcache_line_memory;

  localparam int LAT = 10;
  localparam int AW  = 9;
  localparam int NL  = 1 << AW;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic         enable_i;
  logic         write_i;
  logic         ack_o;
  logic [255:0] data_o;
  logic         busy_o;

  int errs   = 0;
  int checks = 0;

  logic [255:0] mdl [NL];
  bit           known [NL];
  int           wq [$];
  logic [255:0] exp_dout;

  dcache_line_memory #(.LATENCY(LAT), .ADDR_W(AW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .ack_o    (ack_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % NL);
  endfunction

  // One full transaction; returns one edge after ack (state back in IDLE).
  task automatic txn(input bit wr, input logic [31:0] a,
                     input logic [255:0] d, input bit churn,
                     input bit hold);
    int li;
    li = line_of(a);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = a;
    data_i   = d;
    @(posedge clk_i); #1;
    chk("accept_busy", busy_o, 1'b1);
    chk("accept_ack", ack_o, 1'b0);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk_i);
      if (churn) begin
        addr_i  = $urandom;
        data_i  = rnd_line();
        write_i = $urandom_range(0, 1);
      end
      @(posedge clk_i); #1;
      if (k == LAT) begin
        if (wr) begin
          mdl[li]   = d;
          if (!known[li]) wq.push_back(li);
          known[li] = 1'b1;
        end else begin
          exp_dout = mdl[li];
        end
      end
      chk("ack_timing", ack_o, (k == LAT));
      chk("busy_inflight", busy_o, 1'b1);
      chk("data_o", data_o, exp_dout);
    end
    @(negedge clk_i);
    if (!hold) enable_i = 1'b0;
    @(posedge clk_i); #1;
    chk("ack_drop", ack_o, 1'b0);
    chk("busy_idle", busy_o, 1'b0);
    chk("data_o_hold", data_o, exp_dout);
  endtask

  initial begin
    logic [255:0] a5;
    logic [255:0] old800;
    logic [255:0] new400;
    logic [31:0]  ra;
    int           li;
    a5       = {32{8'hA5}};
    exp_dout = '0;
    rst_i    = 1'b0;
    enable_i = 1'b0;
    write_i  = 1'b0;
    addr_i   = '0;
    data_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_data", data_o, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("idle_busy", busy_o, 1'b0);

    // Basic write then read of the same line.
    txn(1'b1, 32'h0000_0040, a5, 1'b0, 1'b0);
    txn(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
    chk("rd_a5", data_o, a5);

    // Write-back then refill with enable held across both.
    old800 = rnd_line();
    new400 = rnd_line();
    txn(1'b1, 32'h0000_0800, old800, 1'b0, 1'b0);
    txn(1'b1, 32'h0000_0400, new400, 1'b0, 1'b1);
    txn(1'b0, 32'h0000_0800, '0, 1'b0, 1'b0);
    chk("refill_old", data_o, old800);
    txn(1'b0, 32'h0000_0400, '0, 1'b0, 1'b0);
    chk("wb_new", data_o, new400);

    // Index wrap: upper address bits and offset ignored.
    txn(1'b1, 32'h0000_0020, rnd_line(), 1'b0, 1'b0);
    txn(1'b0, 32'h0000_4020, '0, 1'b0, 1'b0);
    chk("wrap", data_o, mdl[1]);

    // Reset in the middle of a write to the A5 line.
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h0000_0040;
    data_i   = rnd_line();
    @(posedge clk_i);
    repeat (4) @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    #1;
    chk("midrst_ack", ack_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_data", data_o, '0);
    exp_dout = '0;
    @(negedge clk_i);
    enable_i = 1'b0;
    rst_i    = 1'b1;
    txn(1'b0, 32'h0000_0040, '0, 1'b0, 1'b0);
    chk("midrst_old", data_o, a5);

    // Input churn while busy must not disturb the latched request.
    txn(1'b1, 32'h0000_1000, rnd_line(), 1'b1, 1'b0);
    txn(1'b0, 32'h0000_1000, '0, 1'b1, 1'b0);
    chk("churn", data_o, mdl[line_of(32'h0000_1000)]);

    // Random mix of writes and reads of known lines.
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 2) == 0 || wq.size() == 0) begin
        ra = $urandom;
        txn(1'b1, ra, rnd_line(), $urandom_range(0, 1),
            (n != 23) && $urandom_range(0, 1));
      end else begin
        li = wq[$urandom_range(0, wq.size() - 1)];
        ra = ($urandom & ~32'h0000_3FE0) | (32'(li) << 5);
        txn(1'b0, ra, '0, $urandom_range(0, 1),
            (n != 23) && $urandom_range(0, 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
